// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Bridges a single-issue core to a word-organised data memory. One load or
// store is accepted at a time. Byte and half-word stores are lane-replicated
// and qualified with byte enables. Load data is extracted from the addressed
// lane and sign- or zero-extended. Misaligned or illegal accesses complete
// with an error pulse and never reach the memory.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-high reset
//   valid_i      : core requests a load/store this cycle
//   ready_o      : unit idle, can accept valid_i
//   we_i         : 1 = store, 0 = load
//   funct3_i     : access size/sign (instruction bits [14:12])
//   addr_i       : byte address
//   wdata_i      : store data
//   rdata_o      : extended load result, held until the next successful load
//   done_o       : one-cycle completion pulse
//   err_o        : one-cycle pulse for misaligned or illegal access
//   stall_o      : core must hold PC / write-back
//   mem_req_o    : memory request
//   mem_we_o     : memory write
//   mem_addr_o   : word address (addr_i[MEM_AW+1:2])
//   mem_be_o     : byte enables
//   mem_wdata_o  : lane-aligned write data
//   mem_gnt_i    : memory accepted request
//   mem_rvalid_i : read data valid
//   mem_rdata_i  : read word
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int MEM_AW = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              we_i,
    input  logic [2:0]        funct3_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              done_o,
    output logic              err_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    // Legal size/sign codes; alignment must match the access size.
    function automatic logic access_legal(input logic we, input logic [2:0] f3,
                                          input logic [1:0] off);
        logic ok;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = (off[0] == 1'b0);
            3'b010:  ok = (off == 2'b00);
            3'b100:  ok = !we;
            3'b101:  ok = !we && (off[0] == 1'b0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte enables; funct3[1:0] encodes the size for both signed and unsigned forms.
    function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate narrow store data across all lanes so the byte enables pick it.
    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] res;
        case (f3[1:0])
            2'b00:   res = {4{wd[7:0]}};
            2'b01:   res = {2{wd[15:0]}};
            default: res = wd;
        endcase
        return res;
    endfunction

    // Shift the addressed lane down to bit 0, then extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [31:0] lane;
        logic [31:0] res;
        lane = word >> {off, 3'b000};
        case (f3)
            3'b000:  res = {{24{lane[7]}}, lane[7:0]};
            3'b001:  res = {{16{lane[15]}}, lane[15:0]};
            3'b100:  res = {24'h000000, lane[7:0]};
            3'b101:  res = {16'h0000, lane[15:0]};
            3'b010:  res = word;
            default: res = word;
        endcase
        return res;
    endfunction

    logic [2:0]        state_r;
    logic [2:0]        state_nxt_s;
    logic              we_r;
    logic [2:0]        funct3_r;
    logic [1:0]        off_r;
    logic [MEM_AW-1:0] mem_addr_r;
    logic [3:0]        mem_be_r;
    logic [31:0]       mem_wdata_r;
    logic [31:0]       rdata_r;
    logic              legal_s;
    logic              unused_s;

    // Address bits above the memory window are dropped so the word address wraps.
    assign unused_s = ^addr_i[31:MEM_AW+2];

    assign legal_s = access_legal(we_i, funct3_i, addr_i[1:0]);

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (valid_i) begin
                    if (legal_s) begin
                        state_nxt_s = ST_REQ;
                    end else begin
                        state_nxt_s = ST_ERR;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_gnt_i) begin
                    if (we_r) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            ST_ERR:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Capture the request and precompute memory-side fields when accepted in IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_r        <= 1'b0;
            funct3_r    <= 3'b000;
            off_r       <= 2'b00;
            mem_addr_r  <= '0;
            mem_be_r    <= 4'b0000;
            mem_wdata_r <= 32'h0000_0000;
        end else if ((state_r == ST_IDLE) && valid_i) begin
            we_r        <= we_i;
            funct3_r    <= funct3_i;
            off_r       <= addr_i[1:0];
            mem_addr_r  <= addr_i[MEM_AW+1:2];
            mem_be_r    <= byte_enables(funct3_i, addr_i[1:0]);
            mem_wdata_r <= lane_wdata(funct3_i, wdata_i);
        end
    end

    // Load result register; only updated by read data returning in WAIT.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_r <= 32'h0000_0000;
        end else if ((state_r == ST_WAIT) && mem_rvalid_i) begin
            rdata_r <= load_extend(funct3_r, off_r, mem_rdata_i);
        end
    end

    assign ready_o     = (state_r == ST_IDLE);
    assign done_o      = (state_r == ST_DONE) || (state_r == ST_ERR);
    assign err_o       = (state_r == ST_ERR);
    assign stall_o     = ((state_r == ST_IDLE) && valid_i) ||
                         (state_r == ST_REQ) || (state_r == ST_WAIT);
    assign mem_req_o   = (state_r == ST_REQ);
    assign mem_we_o    = (state_r == ST_REQ) && we_r;
    assign mem_addr_o  = mem_addr_r;
    assign mem_be_o    = mem_be_r;
    assign mem_wdata_o = mem_wdata_r;
    assign rdata_o     = rdata_r;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit: directed self-checking bench for load_store_unit.
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic        we_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        done_o;
    logic        err_o;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [9:0]  mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rdata = 32'h0000_0000;

    always #5 clk_i = ~clk_i;

    load_store_unit #(.MEM_AW(10)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .we_i(we_i), .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .rdata_o(rdata_o), .done_o(done_o), .err_o(err_o), .stall_o(stall_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Let combinational outputs settle after driving inputs.
    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; valid_i = 1'b0; we_i = 1'b0; funct3_i = 3'b000;
        addr_i = 32'h0; wdata_i = 32'h0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        mem_rdata_i = 32'h0;
        tick(); tick();
        rst_i = 1'b0;
        settle();
        checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready_o); end
        checks++; if ({mem_req_o, done_o, err_o, stall_o} !== 4'b0000) begin errors++; $display("FAIL reset_ctl got %b exp 0000", {mem_req_o, done_o, err_o, stall_o}); end
        checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", rdata_o); end
    endtask

    // Zero-wait store: done_o two cycles after acceptance.
    task automatic do_store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [9:0] exp_addr,
                            input logic [3:0] exp_be, input logic [31:0] exp_wd);
        valid_i = 1'b1; we_i = 1'b1; funct3_i = f3; addr_i = addr; wdata_i = wd;
        settle();
        checks++; if ({ready_o, stall_o, mem_req_o} !== 3'b110) begin errors++; $display("FAIL %s accept got %b exp 110", name, {ready_o, stall_o, mem_req_o}); end
        tick();
        valid_i = 1'b0; wdata_i = 32'h0; mem_gnt_i = 1'b1;
        settle();
        checks++; if ({mem_req_o, mem_we_o, done_o} !== 3'b110) begin errors++; $display("FAIL %s req got %b exp 110", name, {mem_req_o, mem_we_o, done_o}); end
        checks++; if (mem_addr_o !== exp_addr) begin errors++; $display("FAIL %s addr got %h exp %h", name, mem_addr_o, exp_addr); end
        checks++; if (mem_be_o !== exp_be) begin errors++; $display("FAIL %s be got %b exp %b", name, mem_be_o, exp_be); end
        checks++; if (mem_wdata_o !== exp_wd) begin errors++; $display("FAIL %s wdata got %h exp %h", name, mem_wdata_o, exp_wd); end
        tick();
        mem_gnt_i = 1'b0;
        settle();
        checks++; if ({done_o, err_o, stall_o, mem_req_o} !== 4'b1000) begin errors++; $display("FAIL %s done got %b exp 1000", name, {done_o, err_o, stall_o, mem_req_o}); end
        tick();
        checks++; if ({ready_o, done_o} !== 2'b10) begin errors++; $display("FAIL %s idle got %b exp 10", name, {ready_o, done_o}); end
    endtask

    // Zero-wait load: done_o three cycles after acceptance.
    task automatic do_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] word, input logic [3:0] exp_be,
                           input logic [31:0] exp_rd);
        valid_i = 1'b1; we_i = 1'b0; funct3_i = f3; addr_i = addr;
        tick();
        valid_i = 1'b0; mem_gnt_i = 1'b1;
        settle();
        checks++; if ({mem_req_o, mem_we_o} !== 2'b10) begin errors++; $display("FAIL %s req got %b exp 10", name, {mem_req_o, mem_we_o}); end
        checks++; if (mem_be_o !== exp_be) begin errors++; $display("FAIL %s be got %b exp %b", name, mem_be_o, exp_be); end
        tick();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = word;
        settle();
        checks++; if ({stall_o, mem_req_o, done_o} !== 3'b100) begin errors++; $display("FAIL %s wait got %b exp 100", name, {stall_o, mem_req_o, done_o}); end
        tick();
        mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        settle();
        checks++; if ({done_o, err_o, stall_o} !== 3'b100) begin errors++; $display("FAIL %s done got %b exp 100", name, {done_o, err_o, stall_o}); end
        checks++; if (rdata_o !== exp_rd) begin errors++; $display("FAIL %s rdata got %h exp %h", name, rdata_o, exp_rd); end
        last_rdata = exp_rd;
        tick();
        checks++; if ({ready_o, done_o} !== 2'b10) begin errors++; $display("FAIL %s idle got %b exp 10", name, {ready_o, done_o}); end
    endtask

    // Illegal access: err/done one cycle after acceptance, no memory request.
    task automatic do_illegal(input string name, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr);
        valid_i = 1'b1; we_i = we; funct3_i = f3; addr_i = addr;
        settle();
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL %s req0 got %b exp 0", name, mem_req_o); end
        tick();
        valid_i = 1'b0;
        settle();
        checks++; if ({err_o, done_o, mem_req_o, stall_o} !== 4'b1100) begin errors++; $display("FAIL %s err got %b exp 1100", name, {err_o, done_o, mem_req_o, stall_o}); end
        checks++; if (rdata_o !== last_rdata) begin errors++; $display("FAIL %s rdata got %h exp %h", name, rdata_o, last_rdata); end
        tick();
        checks++; if ({err_o, done_o, mem_req_o, ready_o} !== 4'b0001) begin errors++; $display("FAIL %s idle got %b exp 0001", name, {err_o, done_o, mem_req_o, ready_o}); end
    endtask

    task automatic test_stores();
        do_store("sw", 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 10'h004, 4'b1111, 32'hDEAD_BEEF);
        do_store("sb_wrap", 3'b000, 32'h0000_1005, 32'h0000_00A5, 10'h001, 4'b0010, 32'hA5A5_A5A5);
        do_store("sh_hi", 3'b001, 32'hFFFF_F002, 32'h1234_ABCD, 10'h000, 4'b1100, 32'hABCD_ABCD);
    endtask

    task automatic test_loads();
        do_load("lb", 3'b000, 32'h0000_0013, 32'h8000_0000, 4'b1000, 32'hFFFF_FF80);
        do_load("lbu", 3'b100, 32'h0000_0013, 32'h8000_0000, 4'b1000, 32'h0000_0080);
        do_load("lh", 3'b001, 32'h0000_0002, 32'h8001_1234, 4'b1100, 32'hFFFF_8001);
        do_load("lhu", 3'b101, 32'h0000_0002, 32'h8001_1234, 4'b1100, 32'h0000_8001);
        do_load("lb_b1", 3'b000, 32'h0000_0021, 32'h0000_7F00, 4'b0010, 32'h0000_007F);
        do_load("lh_lo", 3'b001, 32'h0000_0000, 32'h0000_9ABC, 4'b0011, 32'hFFFF_9ABC);
        do_load("lw", 3'b010, 32'h0000_0FFC, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
    endtask

    task automatic test_illegal();
        do_illegal("lw_mis", 1'b0, 3'b010, 32'h0000_0006);
        do_illegal("sb_f100", 1'b1, 3'b100, 32'h0000_0000);
        do_illegal("lh_odd", 1'b0, 3'b001, 32'h0000_0003);
        do_illegal("f011", 1'b0, 3'b011, 32'h0000_0000);
        do_illegal("lhu_odd", 1'b0, 3'b101, 32'h0000_0001);
    endtask

    // Delayed grant and rvalid; a second valid_i while busy must be ignored.
    task automatic test_wait_states();
        valid_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h0000_0020;
        wdata_i = 32'h5555_5555;
        tick();
        addr_i = 32'h0000_0044; wdata_i = 32'h0; we_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_gnt_i = (i == 3);
            settle();
            checks++; if ({mem_req_o, mem_we_o, stall_o, done_o, ready_o} !== 5'b10100) begin errors++; $display("FAIL ws_req%0d got %b exp 10100", i, {mem_req_o, mem_we_o, stall_o, done_o, ready_o}); end
            checks++; if ({mem_addr_o, mem_be_o, mem_wdata_o} !== {10'h008, 4'b1111, 32'h5555_5555}) begin errors++; $display("FAIL ws_hold%0d got %h/%b/%h exp 008/1111/55555555", i, mem_addr_o, mem_be_o, mem_wdata_o); end
            tick();
        end
        mem_gnt_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mem_rvalid_i = (i == 1); mem_rdata_i = 32'h1122_3344;
            settle();
            checks++; if ({stall_o, mem_req_o, done_o} !== 3'b100) begin errors++; $display("FAIL ws_wait%0d got %b exp 100", i, {stall_o, mem_req_o, done_o}); end
            tick();
        end
        mem_rvalid_i = 1'b0; valid_i = 1'b0;
        settle();
        checks++; if ({done_o, stall_o} !== 2'b10) begin errors++; $display("FAIL ws_done got %b exp 10", {done_o, stall_o}); end
        checks++; if (rdata_o !== 32'h1122_3344) begin errors++; $display("FAIL ws_rdata got %h exp 11223344", rdata_o); end
        tick();
        checks++; if ({done_o, ready_o, mem_req_o} !== 3'b010) begin errors++; $display("FAIL ws_idle got %b exp 010", {done_o, ready_o, mem_req_o}); end
    endtask

    // Reset during WAIT; the late rvalid must not complete or update rdata.
    task automatic test_reset_in_wait();
        valid_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h0000_0040;
        tick();
        valid_i = 1'b0; mem_gnt_i = 1'b1;
        tick();
        mem_gnt_i = 1'b0; rst_i = 1'b1;
        tick();
        rst_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
        settle();
        checks++; if ({ready_o, done_o, stall_o, mem_req_o} !== 4'b1000) begin errors++; $display("FAIL rw_idle got %b exp 1000", {ready_o, done_o, stall_o, mem_req_o}); end
        checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL rw_rdata got %h exp 0", rdata_o); end
        tick();
        mem_rvalid_i = 1'b0;
        settle();
        checks++; if ({ready_o, done_o, err_o} !== 3'b100) begin errors++; $display("FAIL rw_after got %b exp 100", {ready_o, done_o, err_o}); end
        checks++; if (rdata_o !== 32'h0) begin errors++; $display("FAIL rw_rdata2 got %h exp 0", rdata_o); end
    endtask

    initial begin
        test_reset();
        test_stores();
        test_loads();
        test_illegal();
        test_wait_states();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter MEM_AW SHALL be: MEM_AW, 10, data-memory word-address width.
REQ-003 The ports SHALL be, one per line (name, direction, width, meaning):
 clk_i  in  1  clock, rising edge
 rst_i  in  1  synchronous active-high reset
 valid_i  in  1  core requests a load/store this cycle
 ready_o  out  1  unit idle, can accept valid_i
 we_i  in  1  1=store, 0=load
 funct3_i  in  3  instruction bits [14:12], access size/sign
 addr_i  in  32  byte address, the ALU result
 wdata_i  in  32  store data, rs2 value
 rdata_o  out  32  extended load result
 done_o  out  1  one-cycle completion pulse
 err_o  out  1  one-cycle pulse, misaligned or illegal access
 stall_o  out  1  core must hold PC/write-back
 mem_req_o  out  1  memory request
 mem_we_o  out  1  memory write
 mem_addr_o  out  MEM_AW  word address = addr_i[MEM_AW+1:2]
 mem_be_o  out  4  byte enables
 mem_wdata_o  out  32  lane-aligned write data
 mem_gnt_i  in  1  memory accepted request
 mem_rvalid_i  in  1  read data valid
 mem_rdata_i  in  32  read word

Function
REQ-004 The FSM SHALL have states IDLE, REQ, WAIT, DONE, ERR.
REQ-005 IDLE: ready_o=1; valid_i=1 latches we_i, funct3_i, addr_i, wdata_i; next state ERR if access is illegal, else REQ.
REQ-006 Legal funct3 SHALL be 000 (byte), 001 (half), 010 (word) for loads and stores, and 100 (LBU) and 101 (LHU) for loads only; any other value is illegal.
REQ-007 Misaligned accesses (half with addr[0]=1, word with addr[1:0]!=0) SHALL be illegal.
REQ-008 ERR SHALL assert err_o=1 and done_o=1 for one cycle, issue no memory request, leave rdata_o unchanged, then go to IDLE.
REQ-009 REQ SHALL assert mem_req_o with mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o held stable until mem_gnt_i=1.
REQ-010 On gnt, a store SHALL go to DONE and a load SHALL go to WAIT.
REQ-011 mem_rvalid_i SHALL be sampled only in WAIT; the memory guarantees rvalid no earlier than the cycle after gnt.
REQ-012 WAIT: on rvalid, rdata_o SHALL be registered with the extended lane, then the FSM goes to DONE.
REQ-013 DONE SHALL assert done_o=1 for one cycle, then go to IDLE; rdata_o SHALL hold until the next successful load.
REQ-014 Byte enables SHALL be: byte 4'b0001<<addr[1:0]; half 4'b0011 if addr[1]=0, else 4'b1100; word 4'b1111.
REQ-015 mem_wdata_o SHALL be the byte replicated x4 for byte accesses, the half replicated x2 for half accesses, and wdata unchanged for word accesses.
REQ-016 Load extraction SHALL select the lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, and LW passes the word through.
REQ-017 addr_i bits above MEM_AW+1 SHALL be ignored, so the word address wraps.
REQ-018 stall_o SHALL be (IDLE and valid_i) or state in {REQ, WAIT}; stall_o SHALL be 0 in DONE and ERR.
REQ-019 valid_i outside IDLE SHALL be ignored.
REQ-020 Minimum latency with zero-wait memory: a store is accepted at T with done_o at T+2; a load is accepted at T with done_o at T+3.

Reset
REQ-021 rst_i=1 at a clock edge SHALL force IDLE from any state, with mem_req_o=0, done_o=0, err_o=0, stall_o=0, rdata_o=0 and ready_o=1 at the next cycle.
REQ-022 A late mem_rvalid_i arriving after a reset mid-operation SHALL be ignored.

Verification
REQ-023 SW, addr 0x10, data 0xDEADBEEF, gnt in the first REQ cycle -> mem_addr_o=0x004, mem_be_o=1111, mem_wdata_o=0xDEADBEEF, done_o at T+2.
REQ-024 LB then LBU at addr 0x13, mem word 0x80000000 -> rdata_o=0xFFFFFF80, then 0x00000080; be=1000.
REQ-025 LH then LHU at addr 0x02, mem word 0x80011234 -> rdata_o=0xFFFF8001, then 0x00008001; be=1100.
REQ-026 LW at addr 0x06, and separately SB with funct3=100 -> err_o=1 and done_o=1 at T+1, mem_req_o never asserted.
REQ-027 LW with gnt delayed 3 cycles and rvalid 2 cycles after gnt -> mem_req_o and its outputs stable throughout, stall_o=1 until DONE, done_o exactly one cycle after rvalid.
REQ-028 rst_i pulsed in WAIT, followed by rvalid with 0x12345678 -> FSM in IDLE, rdata_o=0, no done_o.
